// File: rtl/seg7_pkg.sv
// Shared constants for the seg7_scan4 display stage: digit count,
// active-high segment patterns (bit0=a .. bit6=g) and scanner states.
package seg7_pkg;

  localparam int DIGITS = 4;

  localparam logic [6:0] SEG_0    = 7'h3F;
  localparam logic [6:0] SEG_1    = 7'h06;
  localparam logic [6:0] SEG_2    = 7'h5B;
  localparam logic [6:0] SEG_3    = 7'h4F;
  localparam logic [6:0] SEG_4    = 7'h66;
  localparam logic [6:0] SEG_5    = 7'h6D;
  localparam logic [6:0] SEG_6    = 7'h7D;
  localparam logic [6:0] SEG_7    = 7'h07;
  localparam logic [6:0] SEG_8    = 7'h7F;
  localparam logic [6:0] SEG_9    = 7'h6F;
  localparam logic [6:0] SEG_DASH = 7'h40;

  typedef logic [0:0] state_t;
  localparam state_t ST_IDLE = 1'b0;
  localparam state_t ST_SCAN = 1'b1;

endpackage

// File: rtl/seg7_scan4_bcd_to_seg7.sv
// Combinational BCD to seven-segment decoder, active-high output.
// Codes 10-15 are not BCD and show a dash so bad upstream data is visible.
module bcd_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  // Look up the segment pattern for one BCD digit
  always_comb begin
    seg_o = SEG_DASH;
    case (bcd_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg7_scan4.sv
// Four-digit multiplexed seven-segment driver. Inputs are captured once
// per frame so the shown number never tears while the counters move.
// All decode logic works in active-high form; polarity is applied only
// where the output registers are loaded.
module seg7_scan4
  import seg7_pkg::*;
#(
  parameter int SCAN_DIV = 50000,
  parameter bit ACT_LOW  = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [15:0]   bcd_in,
  input  logic [3:0]    dp_mask,
  input  logic          blank_lz,
  output logic [6:0]    seg,
  output logic          dp,
  output logic [3:0]    an,
  output logic          frame_done
);

  localparam int             DW       = $clog2(SCAN_DIV);
  localparam logic [DW-1:0]  DIV_LAST = DW'(SCAN_DIV - 1);

  state_t                       state_q, state_d;
  logic [DW-1:0]                div_q, div_d;
  logic [1:0]                   dig_q, dig_d;
  logic [4*DIGITS-1:0]          snapBcd_q, snapBcd_d;
  logic [DIGITS-1:0]            snapDp_q, snapDp_d;
  logic                         snapLz_q, snapLz_d;
  logic                         frameEnd;

  logic [3:0]                   curNib;
  logic [6:0]                   decSeg;
  logic [DIGITS-1:0]            zeroFrom;
  logic                         blankDigit;
  logic [3:0]                   litAn;
  logic [6:0]                   litSeg;
  logic                         litDp;

  logic [3:0]                   an_q;
  logic [6:0]                   seg_q;
  logic                         dp_q;
  logic                         fd_q;

  // Scanner sequencing: dwell counter, digit pointer and frame-boundary snapshot
  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    dig_d     = dig_q;
    snapBcd_d = snapBcd_q;
    snapDp_d  = snapDp_q;
    snapLz_d  = snapLz_q;
    frameEnd  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (en) begin
          state_d   = ST_SCAN;
          div_d     = '0;
          dig_d     = 2'd0;
          snapBcd_d = bcd_in;
          snapDp_d  = dp_mask;
          snapLz_d  = blank_lz;
        end
      end
      ST_SCAN: begin
        if (!en) begin
          state_d = ST_IDLE;
          div_d   = '0;
          dig_d   = 2'd0;
        end else if (div_q == DIV_LAST) begin
          div_d = '0;
          dig_d = dig_q + 2'd1;
          if (dig_q == 2'd3) begin
            frameEnd  = 1'b1;
            snapBcd_d = bcd_in;
            snapDp_d  = dp_mask;
            snapLz_d  = blank_lz;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Sequencer registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      div_q     <= '0;
      dig_q     <= 2'd0;
      snapBcd_q <= '0;
      snapDp_q  <= '0;
      snapLz_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      dig_q     <= dig_d;
      snapBcd_q <= snapBcd_d;
      snapDp_q  <= snapDp_d;
      snapLz_q  <= snapLz_d;
    end
  end

  assign curNib = snapBcd_q[{dig_q, 2'b00} +: 4];

  bcd_to_seg7 u_dec (
    .bcd_i (curNib),
    .seg_o (decSeg)
  );

  // A digit is a leading zero when it and every digit above it are zero
  always_comb begin
    zeroFrom[3] = (snapBcd_q[15:12] == 4'd0);
    zeroFrom[2] = (snapBcd_q[11:8]  == 4'd0) && zeroFrom[3];
    zeroFrom[1] = (snapBcd_q[7:4]   == 4'd0) && zeroFrom[2];
    zeroFrom[0] = (snapBcd_q[3:0]   == 4'd0) && zeroFrom[1];
    blankDigit  = snapLz_q && (dig_q != 2'd0) && zeroFrom[dig_q];
  end

  // Active-high drive for the digit currently selected; dark outside SCAN
  always_comb begin
    litAn  = 4'b0000;
    litSeg = 7'h00;
    litDp  = 1'b0;
    if (state_q == ST_SCAN) begin
      litAn  = 4'b0001 << dig_q;
      litSeg = blankDigit ? 7'h00 : decSeg;
      litDp  = snapDp_q[dig_q];
    end
  end

  // Output registers; the only place display polarity is applied
  always_ff @(posedge clk) begin
    if (!rst) begin
      an_q  <= {4{ACT_LOW}};
      seg_q <= {7{ACT_LOW}};
      dp_q  <= ACT_LOW;
      fd_q  <= 1'b0;
    end else begin
      an_q  <= litAn ^ {4{ACT_LOW}};
      seg_q <= litSeg ^ {7{ACT_LOW}};
      dp_q  <= litDp ^ ACT_LOW;
      fd_q  <= frameEnd;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign frame_done = fd_q;

endmodule

// File: doc/seg7_scan4.md
Name: seg7_scan4

Overview:
- Downstream display stage for the decade-counter chain.
- Takes four BCD digits, normally from four cascaded count_10 stages, and drives a multiplexed 4-digit common-anode seven-segment display.
- Time-multiplexes the digits with a programmable dwell time and decodes BCD to segment patterns.
- Snapshots its inputs once per frame so the displayed value never tears while the counters advance.

Parameters:
- SCAN_DIV, 50000, clk cycles each digit stays lit (>=2); use 4 in simulation.
- ACT_LOW, 1, 1: segments, dp and anodes are active-low; 0: active-high.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-low reset.
- en  in  1  display enable; 0 blanks the display and idles the scanner.
- bcd_in  in  16  digit k = bcd_in[4k+3:4k]; digit0 is least significant.
- dp_mask  in  4  bit k=1 lights the decimal point of digit k.
- blank_lz  in  1  1 enables leading-zero blanking.
- seg  out  7  segment drive, seg[0]=a … seg[6]=g.
- dp  out  1  decimal-point drive.
- an  out  4  anode select, an[k] drives digit k.
- frame_done  out  1  one-cycle pulse at the end of each complete frame.

Behaviour:
- Polarity: "off" means all bits 1 when ACT_LOW=1, all bits 0 when ACT_LOW=0; "lit" is the opposite level.
- Reset (rst=0 at a clk edge):
  - state=IDLE; div_cnt, dig and snapshot registers cleared.
  - an, seg and dp off; frame_done=0.
  - Applies immediately from any state, including mid-frame.
- State IDLE:
  - Outputs off.
  - When en=1 is sampled: load snapshot from bcd_in, dp_mask and blank_lz; dig<=0; div_cnt<=0; go to SCAN.
- State SCAN:
  - div_cnt counts 0..SCAN_DIV-1.
  - At div_cnt=SCAN_DIV-1: div_cnt<=0 and dig<=dig+1, wrapping 3->0.
  - On the 3->0 wrap, reload the snapshot in the same cycle and pulse frame_done=1 for exactly that one cycle.
  - Input changes at any other time are ignored until the next frame.
- Outputs are registered: an/seg/dp reflect dig and the snapshot with 1-cycle latency.
  - The first lit digit appears 2 cycles after en is sampled high.
- Anode select: exactly one an bit is lit in SCAN, namely an[dig].
- BCD decode:
  - Values 0-9 use standard patterns.
  - Values 10-15 are illegal and display "-" (only g lit).
- Leading-zero blanking (snapshot blank_lz=1):
  - Digit k>0 shows all segments off if it and every more-significant digit equal 0.
  - Digit0 is never blanked.
  - dp follows dp_mask regardless of blanking.
- en=0 sampled in SCAN:
  - Next state is IDLE and counters clear.
  - Outputs go off on the following cycle.
  - frame_done is not pulsed for the partial frame.
- Full-frame length is 4*SCAN_DIV cycles.

Decomposition:
- Package seg7_pkg holds:
  - SEG_* patterns for 0-9 and dash, in active-high form.
  - The IDLE/SCAN state enum.
  - The DIGITS=4 constant.
- ACT_LOW inversion is applied once, at the output register.
- One natural sub-module: bcd_to_seg7, a combinational 4-bit BCD in, 7-bit active-high pattern out.

Test Plan (SCAN_DIV=4, ACT_LOW=1):
1. Reset: hold rst=0 for 3 cycles with en=1 -> an=4'hF, seg=7'h7F, dp=1, frame_done=0 throughout.
2. Normal scan: rst=1, en=1, bcd_in=16'h1234, blank_lz=0, dp_mask=0 -> an cycles E,D,B,7 with 4 cycles each, starting 2 cycles after en.
   - seg=7'h19 ("4") with an=E; seg=7'h79 ("1") with an=7.
   - frame_done pulses once every 16 cycles.
3. Leading-zero blanking: bcd_in=16'h0007, blank_lz=1 -> digits 3..1 seg=7'h7F, digit0 seg=7'h78.
   - bcd_in=16'h0000 -> digit0 seg=7'h40, all others 7'h7F.
4. Snapshot: change bcd_in from 16'h1234 to 16'h5678 while an=D -> rest of the frame still shows 3,2,1.
   - Next frame shows 8,7,6,5 (digit0 seg=7'h00).
5. Illegal digit and disable: bcd_in=16'h000C -> digit0 seg=7'h3F.
   - Drop en while an=D -> an=4'hF within 2 cycles, no frame_done pulse.
   - Re-raise en -> restart at digit0.
6. Decimal point: dp_mask=4'b0100 -> dp=0 only while an=B, dp=1 otherwise.
